// File: rtl/velocity_cell_pingpong.sv
// Ping-pong velocity cell memory: reads hit the active bank, writes fill the shadow bank.
// Latency: read data 1 cycle after rd_en; swap_ack 1 cycle after accept. VELOCITY_SHADOW_CLEAR_EN zeroes the new shadow after swap/reset.
// Backpressure: wr_ready low while the shadow is cleared; writes and swaps offered then are dropped, producer holds them.
module velocity_cell_pingpong #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] active_count,
  output logic                  err
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

  logic [DATA_WIDTH-1:0]      ram [0:1][0:DEPTH-1];
  logic [1:0][ADDR_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                       shadow_bank, bank_nxt;
  logic                       swap_acc, wr_acc, wr_ram, rd_oor, wr_oor;
  logic [DATA_WIDTH-1:0]      rd_word;
  logic                       clr_we;
  logic [ADDR_WIDTH-1:0]      clr_addr;

  assign shadow_bank = ~active_bank;
  assign swap_acc    = swap_req & wr_ready;
  assign wr_acc      = wr_en & wr_ready;
  assign rd_oor      = {1'b0, rd_addr} >= DEPTH_W;
  assign wr_oor      = {1'b0, wr_addr} >= DEPTH_W;
  assign wr_ram      = wr_acc & (wr_addr != '0) & ~wr_oor;
  assign bank_nxt    = active_bank ^ swap_acc;

`ifdef VELOCITY_SHADOW_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      clr_addr <= ADDR_WIDTH'(1);
    end else begin
      state_q  <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // IDLE always has wr_ready high, so swap_req alone marks an accepted swap there.
  always_comb begin
    state_nxt    = state_q;
    clr_addr_nxt = clr_addr;
    wr_ready     = 1'b0;
    clr_we       = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (swap_req) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = ADDR_WIDTH'(1);
        end
      end
      CLEAR: begin
        clr_we       = 1'b1;
        clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign wr_ready = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  always_ff @(posedge clock) begin
    if (clr_we)      ram[shadow_bank][clr_addr] <= '0;
    else if (wr_ram) ram[shadow_bank][wr_addr]  <= wr_data;
  end

  // Count write and swap touch different banks, so both can apply in one cycle.
  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_acc && wr_addr == '0) cnt_nxt[shadow_bank] = wr_data[ADDR_WIDTH-1:0];
    if (swap_acc)                cnt_nxt[active_bank] = '0;
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr == '0) rd_word = DATA_WIDTH'(cnt_q[active_bank]);
    else if (!rd_oor)  rd_word = ram[active_bank][rd_addr];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      active_bank  <= 1'b0;
      cnt_q        <= '0;
      active_count <= '0;
      swap_ack     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err          <= 1'b0;
    end else begin
      active_bank  <= bank_nxt;
      cnt_q        <= cnt_nxt;
      active_count <= cnt_nxt[bank_nxt];
      swap_ack     <= swap_acc;
      rd_valid     <= rd_en;
      if (rd_en) rd_data <= rd_word;
      if ((rd_en && rd_oor) || (wr_acc && wr_oor)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Randomised and directed bench for velocity_cell_pingpong against a bank-level reference model.
module tb_velocity_cell_pingpong;
  localparam int DW = 96;
  localparam int D  = 200;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          active_bank;
  logic [AW-1:0] active_count;
  logic          err;

  always #5 clock = ~clock;

  velocity_cell_pingpong #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .active_bank(active_bank), .active_count(active_count), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: two banks of records, two counts, which bank is read.
  logic [DW-1:0] m_ram   [2][D];
  bit            m_known [2][D];
  logic [AW-1:0] m_cnt   [2];
  bit            m_bank, m_err;
  int            m_clear_left;
  logic [DW-1:0] exp_rd_data;
  bit            exp_rd_known, exp_rd_valid, exp_swap_ack, exp_wr_ready;

  task automatic model_reset();
    m_bank = 1'b0; m_cnt[0] = '0; m_cnt[1] = '0; m_err = 1'b0;
    exp_rd_data = '0; exp_rd_known = 1'b1; exp_rd_valid = 1'b0; exp_swap_ack = 1'b0;
`ifdef VELOCITY_SHADOW_CLEAR_EN
    m_clear_left = D - 1;
    for (int a = 1; a < D; a++) begin m_ram[1][a] = '0; m_known[1][a] = 1'b1; end
`else
    m_clear_left = 0;
`endif
    exp_wr_ready = (m_clear_left == 0);
  endtask

  task automatic tick(input bit r_en, input int r_addr, input bit w_en, input int w_addr,
                      input logic [DW-1:0] w_dat, input bit s_req);
    bit ready, s_acc, w_acc;
    rd_en = r_en; rd_addr = AW'(r_addr); wr_en = w_en; wr_addr = AW'(w_addr);
    wr_data = w_dat; swap_req = s_req;
    ready = (m_clear_left == 0);
    s_acc = s_req && ready;
    w_acc = w_en && ready;
    exp_rd_valid = r_en;
    if (r_en) begin
      if (r_addr == 0) begin exp_rd_data = DW'(m_cnt[m_bank]); exp_rd_known = 1'b1; end
      else if (r_addr < D) begin exp_rd_data = m_ram[m_bank][r_addr]; exp_rd_known = m_known[m_bank][r_addr]; end
      else begin exp_rd_data = '0; exp_rd_known = 1'b1; m_err = 1'b1; end
    end
    if (w_acc) begin
      if (w_addr == 0) m_cnt[!m_bank] = w_dat[AW-1:0];
      else if (w_addr < D) begin m_ram[!m_bank][w_addr] = w_dat; m_known[!m_bank][w_addr] = 1'b1; end
      else m_err = 1'b1;
    end
    if (m_clear_left > 0) m_clear_left--;
    if (s_acc) begin
      m_cnt[m_bank] = '0;
`ifdef VELOCITY_SHADOW_CLEAR_EN
      m_clear_left = D - 1;
      for (int a = 1; a < D; a++) begin m_ram[m_bank][a] = '0; m_known[m_bank][a] = 1'b1; end
`endif
      m_bank = !m_bank;
    end
    exp_swap_ack = s_acc;
    exp_wr_ready = (m_clear_left == 0);
    @(posedge clock); #1;
    rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr_ready !== 1'b1 && n < D + 8) begin idle(); n++; end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wait_ready timeout wr_ready=%0b want=1", wr_ready); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL reset_swap_ack got=%0b want=0", swap_ack); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL reset_active_bank got=%0b want=0", active_bank); end
    checks++; if (active_count !== '0) begin failures++; $display("FAIL reset_active_count got=%0d want=0", active_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err); end
    checks++; if (wr_ready !== exp_wr_ready) begin failures++; $display("FAIL reset_wr_ready got=%0b want=%0b", wr_ready, exp_wr_ready); end
    rst_n = 1'b1;
    wait_ready();
  endtask

  task automatic test_count();
    logic [DW-1:0] aaaa = {6{16'hAAAA}};
    tick(1'b0, 0, 1'b1, 0, DW'(5), 1'b0);
    tick(1'b0, 0, 1'b1, 3, aaaa, 1'b0);
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL count_swap_ack got=%0b want=1", swap_ack); end
    checks++; if (active_bank !== 1'b1) begin failures++; $display("FAIL count_bank got=%0b want=1", active_bank); end
    checks++; if (active_count !== 8'd5) begin failures++; $display("FAIL count_active_count got=%0d want=5", active_count); end
    tick(1'b1, 3, 1'b0, 0, '0, 1'b0);
    checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL count_ack_pulse got=%0b want=0", swap_ack); end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL count_rd_valid got=%0b want=1", rd_valid); end
    checks++; if (rd_data !== aaaa) begin failures++; $display("FAIL count_rd_addr3 got=%h want=%h", rd_data, aaaa); end
    tick(1'b1, 0, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== DW'(5)) begin failures++; $display("FAIL count_rd_addr0 got=%h want=5", rd_data); end
    idle();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL hold_rd_valid got=%0b want=0", rd_valid); end
    checks++; if (rd_data !== DW'(5)) begin failures++; $display("FAIL hold_rd_data got=%h want=5", rd_data); end
    wait_ready();
  endtask

  task automatic test_isolation();
    logic [DW-1:0] old_v = {$urandom, $urandom, $urandom};
    logic [DW-1:0] new_v = ~old_v;
    tick(1'b0, 0, 1'b1, 7, old_v, 1'b0);
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 7, i == 0, 7, new_v, 1'b0);
      checks++; if (rd_data !== old_v) begin failures++; $display("FAIL iso_before_swap[%0d] got=%h want=%h", i, rd_data, old_v); end
    end
    tick(1'b1, 7, 1'b0, 0, '0, 1'b1);
    checks++; if (rd_data !== old_v) begin failures++; $display("FAIL iso_swap_cycle got=%h want=%h", rd_data, old_v); end
    tick(1'b1, 7, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== new_v) begin failures++; $display("FAIL iso_after_swap got=%h want=%h", rd_data, new_v); end
    wait_ready();
  endtask

  task automatic test_swap_write();
    logic [DW-1:0] z = {$urandom, $urandom, $urandom};
    logic [DW-1:0] y = {$urandom, $urandom, $urandom} ^ {DW{1'b1}};
    tick(1'b0, 0, 1'b1, 2, z, 1'b0);
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    wait_ready();
    tick(1'b1, 2, 1'b1, 2, y, 1'b1);
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL sw_ack got=%0b want=1", swap_ack); end
    checks++; if (rd_data !== z) begin failures++; $display("FAIL sw_old_bank got=%h want=%h", rd_data, z); end
    tick(1'b1, 2, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== y) begin failures++; $display("FAIL sw_new_write got=%h want=%h", rd_data, y); end
    wait_ready();
  endtask

  task automatic test_boundary();
    logic [DW-1:0] v = {$urandom, $urandom, $urandom};
    tick(1'b0, 0, 1'b1, D - 1, v, 1'b0);
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    wait_ready();
    tick(1'b1, D - 1, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== v) begin failures++; $display("FAIL bound_last got=%h want=%h", rd_data, v); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bound_err got=%0b want=0", err); end
  endtask

  function automatic int pick_addr();
    int r = $urandom_range(0, 99);
    if (r < 6) return 0;
    if (r < 9) return D + $urandom_range(0, 255 - D);
    return $urandom_range(1, D - 1);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 1) == 1, pick_addr(), $urandom_range(0, 1) == 1, pick_addr(),
           {$urandom, $urandom, $urandom}, $urandom_range(0, 15) == 0);
      checks++; if (rd_valid !== exp_rd_valid) begin failures++; $display("FAIL rnd_rd_valid[%0d] got=%0b want=%0b", i, rd_valid, exp_rd_valid); end
      if (exp_rd_known) begin
        checks++; if (rd_data !== exp_rd_data) begin failures++; $display("FAIL rnd_rd_data[%0d] got=%h want=%h", i, rd_data, exp_rd_data); end
      end
      checks++; if (swap_ack !== exp_swap_ack) begin failures++; $display("FAIL rnd_swap_ack[%0d] got=%0b want=%0b", i, swap_ack, exp_swap_ack); end
      checks++; if (active_bank !== m_bank) begin failures++; $display("FAIL rnd_bank[%0d] got=%0b want=%0b", i, active_bank, m_bank); end
      checks++; if (active_count !== m_cnt[m_bank]) begin failures++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, active_count, m_cnt[m_bank]); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0b want=%0b", i, err, m_err); end
      checks++; if (wr_ready !== exp_wr_ready) begin failures++; $display("FAIL rnd_wr_ready[%0d] got=%0b want=%0b", i, wr_ready, exp_wr_ready); end
    end
  endtask

  task automatic test_oor();
    do_reset();
    wait_ready();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%0b want=0", err); end
    tick(1'b0, 0, 1'b1, 220, {DW{1'b1}}, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%0b want=1", err); end
    tick(1'b1, 250, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL oor_rd_valid got=%0b want=1", rd_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL oor_rd_data got=%h want=0", rd_data); end
    tick(1'b1, 0, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL oor_count_untouched got=%h want=0", rd_data); end
    repeat (3) idle();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%0b want=1", err); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    int exp_n;
    logic exp_rdy;
`ifdef VELOCITY_SHADOW_CLEAR_EN
    exp_n = D - 1; exp_rdy = 1'b0;
`else
    exp_n = 0; exp_rdy = 1'b1;
`endif
    tick(1'b0, 0, 1'b1, 0, DW'(9), 1'b0);
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    idle(); idle();
    tick(1'b1, 0, 1'b0, 0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL arst_rd_valid got=%0b want=0", rd_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL arst_rd_data got=%h want=0", rd_data); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL arst_bank got=%0b want=0", active_bank); end
    checks++; if (active_count !== '0) begin failures++; $display("FAIL arst_count got=%0d want=0", active_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%0b want=0", err); end
    checks++; if (wr_ready !== exp_rdy) begin failures++; $display("FAIL arst_wr_ready got=%0b want=%0b", wr_ready, exp_rdy); end
    @(posedge clock); #1 rst_n = 1'b1;
    model_reset();
    while (wr_ready !== 1'b1 && n < D + 8) begin idle(); n++; end
    checks++; if (n != exp_n) begin failures++; $display("FAIL arst_clear_len got=%0d want=%0d", n, exp_n); end
  endtask

`ifdef VELOCITY_SHADOW_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    while (wr_ready !== 1'b1 && n < D + 8) begin
      tick(1'b0, 0, 1'b1, 5, {DW{1'b1}}, 1'b1);
      n++;
      checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL clr_ack_in_window[%0d] got=%0b want=0", n, swap_ack); end
    end
    checks++; if (n != D - 1) begin failures++; $display("FAIL clr_window got=%0d want=%0d", n, D - 1); end
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1);
    wait_ready();
    tick(1'b1, 5, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL clr_dropped_write got=%h want=0", rd_data); end
    tick(1'b1, 123, 1'b0, 0, '0, 1'b0);
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL clr_unwritten got=%h want=0", rd_data); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_isolation();
    test_swap_write();
    test_boundary();
    test_random();
    test_oor();
    test_async_reset();
`ifdef VELOCITY_SHADOW_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
